// File: rtl/gf16_mul_arbiter.sv
// Two-requester arbiter in front of a shared masked GF(2^4) multiply unit.
// Picks one requester per cycle (round-robin on ties), muxes its two-share
// operands to the unit, supplies fresh guard bits from a 16-bit LFSR and
// tracks each accepted operation through the unit latency so the result
// strobes back to the requester that issued it.
module gf16_mul_arbiter #(
  parameter int          LAT  = 1,       // unit register latency, 1..4
  parameter logic [15:0] SEED = 16'hACE1 // non-zero LFSR reset value
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [3:0]  a_hgfe0,
  input  logic [3:0]  a_hgfe1,
  input  logic [3:0]  a_dcba0,
  input  logic [3:0]  a_dcba1,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [3:0]  b_hgfe0,
  input  logic [3:0]  b_hgfe1,
  input  logic [3:0]  b_dcba0,
  input  logic [3:0]  b_dcba1,
  output logic [3:0]  u_hgfe0,
  output logic [3:0]  u_hgfe1,
  output logic [3:0]  u_dcba0,
  output logic [3:0]  u_dcba1,
  output logic [3:0]  u_guards,
  input  logic [7:0]  u_res,
  output logic        a_rsp_valid,
  output logic        b_rsp_valid,
  output logic [7:0]  a_rsp_data,
  output logic [7:0]  b_rsp_data,
  input  logic        reseed_valid,
  input  logic [15:0] reseed_data,
  output logic        busy
);

  localparam int STAGES = LAT - 1;

  typedef struct packed {
    logic [3:0] hgfe0;
    logic [3:0] hgfe1;
    logic [3:0] dcba0;
    logic [3:0] dcba1;
  } ops_t;

  ops_t a_ops, b_ops, u_ops;

  logic          last_b;    // 1: requester B was served most recently
  logic          gnt_a, gnt_b, accept;
  logic [15:0]   lfsr, lfsr_nxt;
  logic [STAGES:0] vld_pipe; // per-stage "operation in flight"
  logic [STAGES:0] own_pipe; // per-stage owner, 0 = A, 1 = B

  assign a_ops = {a_hgfe0, a_hgfe1, a_dcba0, a_dcba1};
  assign b_ops = {b_hgfe0, b_hgfe1, b_dcba0, b_dcba1};

  // Grant: reseed blocks everything; a tie goes to whoever was not served last.
  // Held in reset, nothing is granted so ready and unit operands stay at zero.
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_i && !reseed_valid) begin
      if (a_valid && b_valid) begin
        gnt_a = last_b;
        gnt_b = !last_b;
      end else begin
        gnt_a = a_valid;
        gnt_b = b_valid;
      end
    end
  end

  // A grant is only ever given to a valid requester, so grant == acceptance.
  assign a_ready = gnt_a;
  assign b_ready = gnt_b;
  assign accept  = gnt_a | gnt_b;

  // Operand mux: idle cycles present all-zero shares, never stale data.
  always_comb begin
    u_ops = '0;
    if (gnt_a)      u_ops = a_ops;
    else if (gnt_b) u_ops = b_ops;
  end

  assign u_hgfe0  = u_ops.hgfe0;
  assign u_hgfe1  = u_ops.hgfe1;
  assign u_dcba0  = u_ops.dcba0;
  assign u_dcba1  = u_ops.dcba1;
  assign u_guards = accept ? lfsr[3:0] : 4'h0;

  // Fibonacci step, taps 16/14/13/11 (bits 15,13,12,10), shifting left.
  assign lfsr_nxt = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

  // Round-robin pointer and LFSR; the LFSR only moves when guards are consumed.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      last_b <= 1'b1;
      lfsr   <= SEED;
    end else begin
      if (accept) last_b <= gnt_b;
      if (reseed_valid)
        lfsr <= (reseed_data == 16'h0) ? SEED : reseed_data;
      else if (accept)
        lfsr <= lfsr_nxt;
    end
  end

  // Tag pipeline mirroring the unit latency; stage 0 captures every cycle.
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      vld_pipe <= '0;
      own_pipe <= '0;
    end else begin
      vld_pipe[0] <= accept;
      own_pipe[0] <= gnt_b;
      for (int i = 1; i <= STAGES; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        own_pipe[i] <= own_pipe[i-1];
      end
    end
  end

  assign a_rsp_valid = vld_pipe[STAGES] & ~own_pipe[STAGES];
  assign b_rsp_valid = vld_pipe[STAGES] &  own_pipe[STAGES];
  assign a_rsp_data  = a_rsp_valid ? u_res : 8'h00;
  assign b_rsp_data  = b_rsp_valid ? u_res : 8'h00;
  assign busy        = |vld_pipe;

endmodule

// File: tb/tb_gf16_mul_arbiter.sv
// Directed bench for gf16_mul_arbiter. Three instances with LAT = 1, 2, 3
// share every input; index k selects which instance's outputs are examined.
module tb_gf16_mul_arbiter;

  logic        clk;
  logic        rst_i;
  logic        a_valid, b_valid;
  logic [3:0]  a_hgfe0, a_hgfe1, a_dcba0, a_dcba1;
  logic [3:0]  b_hgfe0, b_hgfe1, b_dcba0, b_dcba1;
  logic [7:0]  u_res;
  logic        reseed_valid;
  logic [15:0] reseed_data;

  logic [2:0]       a_ready_w, b_ready_w, a_rsp_valid_w, b_rsp_valid_w, busy_w;
  logic [2:0][3:0]  u_hgfe0_w, u_hgfe1_w, u_dcba0_w, u_dcba1_w, u_guards_w;
  logic [2:0][7:0]  a_rsp_data_w, b_rsp_data_w;

  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_lfsr;
  logic [3:0]  g2 [4];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    gf16_mul_arbiter #(.LAT(g + 1), .SEED(16'hACE1)) dut (
      .clk(clk), .rst_i(rst_i),
      .a_valid(a_valid), .a_ready(a_ready_w[g]),
      .a_hgfe0(a_hgfe0), .a_hgfe1(a_hgfe1), .a_dcba0(a_dcba0), .a_dcba1(a_dcba1),
      .b_valid(b_valid), .b_ready(b_ready_w[g]),
      .b_hgfe0(b_hgfe0), .b_hgfe1(b_hgfe1), .b_dcba0(b_dcba0), .b_dcba1(b_dcba1),
      .u_hgfe0(u_hgfe0_w[g]), .u_hgfe1(u_hgfe1_w[g]),
      .u_dcba0(u_dcba0_w[g]), .u_dcba1(u_dcba1_w[g]),
      .u_guards(u_guards_w[g]), .u_res(u_res),
      .a_rsp_valid(a_rsp_valid_w[g]), .b_rsp_valid(b_rsp_valid_w[g]),
      .a_rsp_data(a_rsp_data_w[g]), .b_rsp_data(b_rsp_data_w[g]),
      .reseed_valid(reseed_valid), .reseed_data(reseed_data),
      .busy(busy_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // A operands read back as 16'h1256, B operands as 16'h9ABC.
  task automatic chk_grant(input string tag, input int k, input logic ga,
                           input logic gb, input logic [3:0] g);
    logic [15:0] eops;
    eops = ga ? 16'h1256 : (gb ? 16'h9ABC : 16'h0000);
    chk({tag, "/rdy"}, {a_ready_w[k], b_ready_w[k]}, {ga, gb});
    chk({tag, "/ops"}, {u_hgfe0_w[k], u_hgfe1_w[k], u_dcba0_w[k], u_dcba1_w[k]}, eops);
    chk({tag, "/grd"}, u_guards_w[k], g);
  endtask

  task automatic chk_rsp(input string tag, input int k, input logic ea,
                         input logic eb, input logic [7:0] d);
    chk({tag, "/rv"}, {a_rsp_valid_w[k], b_rsp_valid_w[k]}, {ea, eb});
    chk({tag, "/ad"}, a_rsp_data_w[k], ea ? d : 8'h00);
    chk({tag, "/bd"}, b_rsp_data_w[k], eb ? d : 8'h00);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    g2[0] = 4'h1; g2[1] = 4'h3; g2[2] = 4'h7; g2[3] = 4'hF;
    rst_i = 1'b0; a_valid = 1'b1; b_valid = 1'b0;
    a_hgfe0 = 4'h1; a_hgfe1 = 4'h2; a_dcba0 = 4'h5; a_dcba1 = 4'h6;
    b_hgfe0 = 4'h9; b_hgfe1 = 4'hA; b_dcba0 = 4'hB; b_dcba1 = 4'hC;
    u_res = 8'h00; reseed_valid = 1'b0; reseed_data = 16'h0000;

    // Held in reset with a_valid high: nothing granted, nothing in flight.
    repeat (2) tick();
    #1;
    chk_grant("rst", 0, 1'b0, 1'b0, 4'h0);
    chk_rsp("rst", 0, 1'b0, 1'b0, 8'h00);
    chk("rst/busy", busy_w, 3'b000);

    // First acceptance after reset: guards = SEED[3:0].
    tick(); rst_i = 1'b1; #1;
    chk_grant("t1", 0, 1'b1, 1'b0, 4'h1);
    tick(); a_valid = 1'b0; u_res = 8'h3C; #1;
    chk_rsp("t1rsp", 0, 1'b1, 1'b0, 8'h3C);
    chk_grant("t1idle", 0, 1'b0, 1'b0, 4'h0);
    chk("t1/busy", busy_w[0], 1'b1);

    // Fresh reset, then both valid for 4 cycles: A,B,A,B with guards 1,3,7,F.
    tick(); rst_i = 1'b0;
    tick(); rst_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick(); a_valid = 1'b1; b_valid = 1'b1; u_res = 8'h10 + 8'(c); #1;
      chk_grant("t2", 0, (c % 2) == 0, (c % 2) == 1, g2[c]);
      if (c > 0) chk_rsp("t2rsp", 0, ((c - 1) % 2) == 0, ((c - 1) % 2) == 1, 8'h10 + 8'(c));
    end
    tick(); a_valid = 1'b0; b_valid = 1'b0; u_res = 8'h20; #1;
    chk_rsp("t2last", 0, 1'b0, 1'b1, 8'h20);
    chk_grant("t2idle", 0, 1'b0, 1'b0, 4'h0);

    // Idle cycle produced no strobe one cycle later.
    tick(); u_res = 8'h21; #1;
    chk_rsp("t3", 0, 1'b0, 1'b0, 8'h00);
    chk("t3/busy", busy_w[0], 1'b0);

    // Reseed with zero while both valid: no grant, LFSR back to SEED, A next.
    tick(); reseed_valid = 1'b1; reseed_data = 16'h0000; a_valid = 1'b1; b_valid = 1'b1; #1;
    chk_grant("t4rs", 0, 1'b0, 1'b0, 4'h0);
    tick(); reseed_valid = 1'b0; #1;
    chk_grant("t4a", 0, 1'b1, 1'b0, 4'h1);
    tick(); #1;
    chk_grant("t4b", 0, 1'b0, 1'b1, 4'h3);
    tick(); reseed_valid = 1'b1; reseed_data = 16'h1234; b_valid = 1'b0; #1;
    chk_grant("t4rs2", 0, 1'b0, 1'b0, 4'h0);
    tick(); reseed_valid = 1'b0; #1;
    chk_grant("t4c", 0, 1'b1, 1'b0, 4'h4);
    tick(); a_valid = 1'b0;

    // LAT=3: A then B accepted, reset pulsed before either result returns.
    rst_i = 1'b0;
    tick(); rst_i = 1'b1;
    tick(); a_valid = 1'b1; #1;
    chk_grant("t5a", 2, 1'b1, 1'b0, 4'h1);
    tick(); a_valid = 1'b0; b_valid = 1'b1; #1;
    chk_grant("t5b", 2, 1'b0, 1'b1, 4'h3);
    chk("t5/busy1", busy_w[2], 1'b1);
    tick(); b_valid = 1'b0; #1;
    chk("t5/busy2", busy_w[2], 1'b1);
    rst_i = 1'b0; #1;
    chk("t5/busyrst", busy_w, 3'b000);
    chk_rsp("t5r", 2, 1'b0, 1'b0, 8'h00);
    tick(); rst_i = 1'b1; u_res = 8'h55; #1;
    chk_rsp("t5c3", 2, 1'b0, 1'b0, 8'h00);
    tick(); #1;
    chk_rsp("t5c4", 2, 1'b0, 1'b0, 8'h00);
    chk("t5/busy4", busy_w[2], 1'b0);
    tick(); a_valid = 1'b1; #1;
    chk_grant("t5seed", 2, 1'b1, 1'b0, 4'h1);
    exp_lfsr = 16'h59C3;
    tick(); a_valid = 1'b0;
    tick();

    // LAT=2: 10 back-to-back A acceptances, strobes at cycles 2..11.
    for (int k = 0; k < 14; k++) begin
      tick(); a_valid = (k < 10); u_res = 8'h80 + 8'(k); #1;
      chk_rsp("t6", 1, (k >= 2) && (k < 12), 1'b0, 8'h80 + 8'(k));
      if (k < 10) begin
        chk_grant("t6g", 1, 1'b1, 1'b0, exp_lfsr[3:0]);
        exp_lfsr = lfsr_step(exp_lfsr);
      end
    end
    chk("t6/busy", busy_w[1], 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/gf16_mul_arbiter.md
Name: gf16_mul_arbiter

Overview:
- Shares one masked GF(2^4) multiply/XOR/square-scale unit between two S-box datapaths (requester A, requester B).
- Each cycle it picks one requester and drives that requester's two-share operands to the shared unit.
- It generates the 4-bit fresh guard randomness for each use from an internal LFSR.
- It tracks in-flight operations through the unit's register latency and routes each result back to the requester that issued it.

Parameters:
- LAT, 1, register latency of the shared unit in cycles (1..4).
- SEED, 16'hACE1, LFSR value after reset; must be non-zero.

Ports:
- clk  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- a_valid  in  1  requester A operands valid.
- a_ready  out  1  requester A operands accepted this cycle.
- a_hgfe0, a_hgfe1, a_dcba0, a_dcba1  in  4 each  requester A shares {h,g,f,e} and {d,c,b,a}.
- b_valid, b_ready, b_hgfe0, b_hgfe1, b_dcba0, b_dcba1  same as A, for requester B.
- u_hgfe0, u_hgfe1, u_dcba0, u_dcba1  out  4 each  operands to the shared unit.
- u_guards  out  4  fresh randomness to the shared unit.
- u_res  in  8  unit result {t[1:0], z[1:0], y[1:0], x[1:0]}.
- a_rsp_valid, b_rsp_valid  out  1 each  one-cycle result strobe.
- a_rsp_data, b_rsp_data  out  8 each  result, equal to u_res when the matching strobe is high, else 0.
- reseed_valid  in  1  load a new LFSR state.
- reseed_data  in  16  new LFSR state.
- busy  out  1  any operation in flight.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - LFSR=SEED, last-served pointer=B (so A wins the first tie), tag pipeline cleared.
  - All ready, rsp_valid and rsp_data outputs 0; busy=0.
- Grant (combinational from the current inputs and registered state):
  - If reseed_valid=1: no grant.
  - Else if exactly one requester is valid: grant it.
  - Else if both are valid: grant the one not last served.
  - x_ready=1 only for the granted requester.
  - Acceptance = x_valid & x_ready.
  - The pointer updates on the clock edge after an accepted grant.
- Operand mux:
  - Granted requester's four operand buses drive u_*.
  - With no grant, u_* and u_guards are all-zero.
  - Idle cycles must never present stale share data to the unit.
- Guards:
  - u_guards = LFSR[3:0] in the cycle of an accepted grant.
  - The LFSR advances on every accepted grant only.
  - Step: Fibonacci, shift left; new bit0 = b15^b13^b12^b10.
- Reseed:
  - When reseed_valid=1, LFSR <= reseed_data at the next edge.
  - If reseed_data=0, load SEED instead (avoids the lock-up state).
  - No grant occurs in a reseed cycle.
- Tag pipeline:
  - LAT-deep shift register of {valid, owner}; stage 0 is written with {accept, owner} every cycle.
  - The last stage drives a_rsp_valid or b_rsp_valid, with x_rsp_data=u_res.
  - Latency: a result strobes exactly LAT cycles after the acceptance cycle.
  - Throughput: one operation per cycle; back-to-back grants are allowed.
  - Requesters have no response backpressure; they must sink results.
- busy = OR of all tag valid bits.
- Reset mid-operation: in-flight tags are discarded; no strobes are produced for them.
- Simultaneous events:
  - reseed_valid with both requesters valid: neither is accepted and the pointer is unchanged.
  - An acceptance in the same cycle as a result strobe is legal and independent of it.

Test Plan:
- Reset release, LAT=1, a_valid=1 only, a_dcba0=4'h5 → a_ready=1, u_dcba0=4'h5, u_guards=4'h1; next cycle a_rsp_valid=1 with a_rsp_data=u_res; LFSR=16'h59C3.
- Both valid for 4 cycles → grant order A,B,A,B; guards 4'h1,4'h3,… follow the LFSR sequence; strobes alternate a/b one cycle later.
- Idle cycle (both valid=0) → all u_* = 0, LFSR unchanged, no strobe LAT cycles later.
- reseed_valid=1, reseed_data=16'h0000 with both valid → no ready; LFSR=16'hACE1 afterwards; arbitration resumes with the same pointer.
- LAT=3, A accepted at cycle 0 and B at cycle 1, rst_i pulsed low at cycle 2 → no rsp strobes, busy=0 immediately, LFSR=SEED.
- LAT=2, continuous A-only traffic for 10 cycles → 10 a_rsp strobes starting at cycle 2, no gaps, b_rsp_valid never 1.
